// File: rtl/mac_pkg.sv
// Shared definitions for the MAC accumulator: default widths and the FSM state encoding.
package mac_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int ACC_W_DEF = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } mac_state_e;

endpackage

// File: rtl/mac_accumulator_if.sv
// Control, product-stream and result handshake bundle between a driver and the accumulator.
interface mac_accumulator_if #(
    parameter int LEN_W = mac_pkg::LEN_W_DEF,
    parameter int ACC_W = mac_pkg::ACC_W_DEF
) ();

    logic             start;
    logic [LEN_W-1:0] len;
    logic             clr;
    logic             prod_valid;
    logic [31:0]      prod_in;
    logic             prod_ready;
    logic [ACC_W-1:0] acc_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [LEN_W-1:0] cnt;

    modport master (
        output start, len, clr, prod_valid, prod_in, out_ready,
        input  prod_ready, acc_out, out_valid, busy, cnt
    );

    modport slave (
        input  start, len, clr, prod_valid, prod_in, out_ready,
        output prod_ready, acc_out, out_valid, busy, cnt
    );

endinterface

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: sums len unsigned 32-bit products, then holds the result
// until the consumer takes it.
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    mac_accumulator_if.slave    bus
);

    mac_state_e       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] cnt_d;
    logic [LEN_W-1:0] len_q;
    logic             busy_q;
    logic             prod_ready_q;
    logic             out_valid_q;

    always_comb begin
        acc_d = acc_q + ACC_W'(bus.prod_in);
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            len_q        <= '0;
            busy_q       <= 1'b0;
            prod_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else if (bus.clr) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            prod_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        len_q <= bus.len;
                        // An empty run skips accumulation and presents a zero result.
                        if (bus.len == '0) begin
                            state_q     <= ST_HOLD;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q      <= ST_ACC;
                            busy_q       <= 1'b1;
                            prod_ready_q <= 1'b1;
                        end
                    end
                end
                ST_ACC: begin
                    if (bus.prod_valid) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (cnt_d == len_q) begin
                            state_q      <= ST_HOLD;
                            busy_q       <= 1'b0;
                            prod_ready_q <= 1'b0;
                            out_valid_q  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result registers are left untouched so acc_out keeps its last value.
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                    prod_ready_q <= 1'b0;
                    out_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.prod_ready = prod_ready_q;
    assign bus.busy       = busy_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.acc_out    = acc_q;
    assign bus.cnt        = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized scoreboard bench for mac_accumulator: run results are predicted from plain sums.
module tb_mac_accumulator;

    localparam int LEN_W = 8;
    localparam int ACC_W = 40;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic [LEN_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_accumulator_if #(.LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

    mac_accumulator #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] prods[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_valid"},  64'(bus.out_valid),  64'd0);
        chk({tag, "_prod_ready"}, 64'(bus.prod_ready), 64'd0);
        chk({tag, "_busy"},       64'(bus.busy),       64'd0);
        chk({tag, "_acc_out"},    64'(bus.acc_out),    64'd0);
        chk({tag, "_cnt"},        64'(bus.cnt),        64'd0);
    endtask

    // One complete run: gap < 0 selects random stall lengths, hold is cycles with out_ready low.
    task automatic do_run(input logic [31:0] p[$], input int gap, input int hold);
        logic [63:0] total;
        logic [63:0] part;
        exp_t        e;
        int          n;
        int          g;
        n     = p.size();
        total = 64'd0;
        foreach (p[i]) total += 64'(p[i]);
        e.acc = total[ACC_W-1:0];
        e.cnt = LEN_W'(n);
        exp_q.push_back(e);

        bus.start = 1'b1;
        bus.len   = LEN_W'(n);
        tick();
        bus.start = 1'b0;
        part      = 64'd0;
        if (n == 0) begin
            chk("len0_out_valid",  64'(bus.out_valid),  64'd1);
            chk("len0_prod_ready", 64'(bus.prod_ready), 64'd0);
            chk("len0_acc",        64'(bus.acc_out),    64'd0);
        end else begin
            chk("start_busy",       64'(bus.busy),       64'd1);
            chk("start_prod_ready", 64'(bus.prod_ready), 64'd1);
        end

        for (int i = 0; i < n; i++) begin
            g = (gap >= 0) ? gap : int'($urandom_range(0, 3));
            for (int k = 0; k < g; k++) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.len   = LEN_W'($urandom);
                tick();
                chk("stall_acc",  64'(bus.acc_out), part);
                chk("stall_cnt",  64'(bus.cnt),     64'(i));
                chk("stall_busy", 64'(bus.busy),    64'd1);
            end
            bus.start      = 1'b0;
            bus.prod_valid = 1'b1;
            bus.prod_in    = p[i];
            tick();
            bus.prod_valid = 1'b0;
            part += 64'(p[i]);
            chk("acc_partial", 64'(bus.acc_out), 64'(part[ACC_W-1:0]));
            chk("cnt_partial", 64'(bus.cnt),     64'(i + 1));
            if (i == n - 1) chk("final_out_valid", 64'(bus.out_valid), 64'd1);
            else            chk("mid_busy",        64'(bus.busy),      64'd1);
        end

        for (int k = 0; k < hold; k++) begin
            bus.start = 1'($urandom_range(0, 1));
            bus.len   = LEN_W'($urandom);
            tick();
            chk("hold_valid",      64'(bus.out_valid),  64'd1);
            chk("hold_acc",        64'(bus.acc_out),    64'(e.acc));
            chk("hold_cnt",        64'(bus.cnt),        64'(e.cnt));
            chk("hold_prod_ready", 64'(bus.prod_ready), 64'd0);
        end
        bus.start     = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("done_out_valid",  64'(bus.out_valid),  64'd0);
        chk("done_busy",       64'(bus.busy),       64'd0);
        chk("done_prod_ready", 64'(bus.prod_ready), 64'd0);
    endtask

    // Monitor: every result handshake must match the oldest predicted run.
    always @(negedge clk) begin
        if (!rst && !bus.clr && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result", 64'(bus.acc_out), 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_acc", 64'(bus.acc_out), 64'(e.acc));
                chk("sb_cnt", 64'(bus.cnt),     64'(e.cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.clr        = 1'b0;
        bus.prod_valid = 1'b0;
        bus.prod_in    = '0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("idle");

        prods = '{32'd10, 32'd20, 32'd30};
        do_run(prods, 0, 1);

        prods = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        do_run(prods, 2, 1);

        prods = {};
        do_run(prods, 0, 2);

        // Abort with clr while a product is offered; that product must not count.
        bus.start = 1'b1;
        bus.len   = LEN_W'(4);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.prod_valid = 1'b1;
            bus.prod_in    = $urandom;
            tick();
        end
        chk("pre_clr_cnt", 64'(bus.cnt), 64'd2);
        bus.prod_in = 32'd5;
        bus.clr     = 1'b1;
        tick();
        bus.clr        = 1'b0;
        bus.prod_valid = 1'b0;
        check_zero("clr");
        tick();
        chk("clr_stays_idle", 64'(bus.busy), 64'd0);

        prods = '{32'd1, 32'd2, 32'd3};
        do_run(prods, 0, 5);

        // Reset mid-run, then a fresh single-product run.
        bus.start = 1'b1;
        bus.len   = LEN_W'(5);
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.prod_valid = 1'b1;
            bus.prod_in    = $urandom;
            tick();
        end
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        bus.prod_valid = 1'b0;
        check_zero("rst_mid");
        prods = '{32'd7};
        do_run(prods, 0, 1);

        for (int r = 0; r < 25; r++) begin
            int n;
            prods.delete();
            n = int'($urandom_range(0, 8));
            for (int i = 0; i < n; i++) prods.push_back($urandom);
            do_run(prods, -1, int'($urandom_range(0, 3)));
        end

        tick();
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
